// File: rtl/store_commit_queue.sv
// Store commit queue: buffers retired stores and drains them in program order to the
// data-memory write port, with a word-address load hazard check and a drain handshake.
module store_commit_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [31:0]                push_wdata,
    input  logic [3:0]                 push_be,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_gnt,
    input  logic                       mem_done,
    input  logic [ADDR_W-1:0]          query_addr,
    output logic                       query_hit,
    input  logic                       sync_req,
    output logic                       sync_done
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     head_q, tail_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]    valid_q;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [31:0]         data_q [DEPTH];
    logic [3:0]          be_q   [DEPTH];

    logic push_ok;
    logic pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop     = ((state_q == StReq) & mem_gnt & mem_done) |
                     ((state_q == StWait) & mem_done);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Idle looks at count_d so a store pushed into an empty queue requests one cycle later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (count_d != '0) state_d = StReq;
            StReq: begin
                if (mem_gnt && mem_done) begin
                    state_d = (count_d != '0) ? StReq : StIdle;
                end else if (mem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_done) state_d = (count_d != '0) ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push_ok) begin
                addr_q[tail_q]  <= push_addr;
                data_q[tail_q]  <= push_wdata;
                be_q[tail_q]    <= push_be;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
        end
    end

    assign mem_req   = (state_q == StReq);
    assign mem_addr  = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign mem_be    = be_q[head_q];
    assign count     = count_q;
    assign empty     = (count_q == '0) && (state_q == StIdle);
    assign sync_done = sync_req & empty;

    // The head stays valid through WAIT, so loads still see the in-flight write.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:2] == query_addr[ADDR_W-1:2])) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule
